// File: rtl/disp_scan_ctrl.sv
// Display stage behind the calculator core: shadow-captures the core's digit stream, commits it
// atomically on busy->ready, and scans 8 common-anode 7-segment digits with LZB and an "Err" screen.
module disp_scan_ctrl #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 2,
    parameter int LZB       = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done,
    output logic       upd
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);

    localparam logic [1:0] ST_ERROR = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'h40;
            4'd1:    glyph = 7'h79;
            4'd2:    glyph = 7'h24;
            4'd3:    glyph = 7'h30;
            4'd4:    glyph = 7'h19;
            4'd5:    glyph = 7'h12;
            4'd6:    glyph = 7'h02;
            4'd7:    glyph = 7'h78;
            4'd8:    glyph = 7'h00;
            4'd9:    glyph = 7'h10;
            default: glyph = SEG_DASH;
        endcase
    endfunction

    logic [7:0][3:0] shadow_q, shadow_d;
    logic [7:0][3:0] bank_q, bank_d;
    logic            err_q, err_d;
    logic [1:0]      status_q;
    logic [PW-1:0]   presc_q, presc_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            fd_q, fd_d;
    logic            upd_q, upd_d;

    logic            commit;
    logic            wrap;
    logic [7:0]      lit;
    logic [6:0]      digit_seg;

    assign commit = (status_q == ST_BUSY) && (status == ST_READY);

    // Commit and capture are mutually exclusive: a commit edge always has status == ready.
    always_comb begin
        shadow_d = shadow_q;
        bank_d   = bank_q;
        err_d    = err_q;
        upd_d    = 1'b0;
        if (commit) begin
            bank_d   = shadow_q;
            shadow_d = '0;
            upd_d    = 1'b1;
        end else if ((status == ST_BUSY) && !pos[3]) begin
            shadow_d[pos[2:0]] = data;
        end
        if (status == ST_ERROR) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        wrap    = (presc_q == PRESC_LAST);
        presc_d = wrap ? '0 : presc_q + 1'b1;
        idx_d   = wrap ? idx_q + 3'd1 : idx_q;
        fd_d    = wrap && (idx_q == 3'd7);
    end

    // A digit is lit when it or any digit above it is nonzero; digit 0 always shows.
    always_comb begin
        lit = '0;
        for (int i = 0; i < 8; i++) begin
            lit[i] = (i == 0) || (LZB == 0);
            for (int j = i; j < 8; j++) begin
                if (bank_q[j] != 4'd0) begin
                    lit[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        digit_seg = SEG_BLANK;
        if (err_q) begin
            case (idx_q)
                3'd2:       digit_seg = SEG_E;
                3'd1, 3'd0: digit_seg = SEG_R;
                default:    digit_seg = SEG_BLANK;
            endcase
        end else if (lit[idx_q]) begin
            digit_seg = glyph(bank_q[idx_q]);
        end
    end

    // Anodes stay off for the first BLANK_CYC clocks of each slot so the previous digit cannot ghost.
    always_comb begin
        an_d  = 8'hFF;
        seg_d = SEG_BLANK;
        if (presc_q >= BLANK_END) begin
            an_d  = ~(8'd1 << idx_q);
            seg_d = digit_seg;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_q <= '0;
            bank_q   <= '0;
            err_q    <= 1'b0;
            status_q <= ST_READY;
            presc_q  <= '0;
            idx_q    <= '0;
            an_q     <= 8'hFF;
            seg_q    <= SEG_BLANK;
            fd_q     <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            bank_q   <= bank_d;
            err_q    <= err_d;
            status_q <= status;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            fd_q     <= fd_d;
            upd_q    <= upd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = 1'b1;
    assign frame_done = fd_q;
    assign upd        = upd_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: a frame-arithmetic reference model feeds an expected
// queue that is compared every cycle, plus literal glyph checks on captured frames.
module tb_disp_scan_ctrl;

    localparam int D     = 8;
    localparam int BLANK = 2;
    localparam int LZB_P = 1;

    localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    // ---------------- clock / reset ----------------
    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] status;
    logic [3:0] data;
    logic [3:0] pos;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;
    logic       upd;

    always #5 clock = ~clock;

    disp_scan_ctrl #(.SCAN_DIV(D), .BLANK_CYC(BLANK), .LZB(LZB_P)) dut (
        .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
        .an(an), .seg(seg), .dp(dp), .frame_done(frame_done), .upd(upd)
    );

    int n_checks = 0;
    int n_errs   = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Scan position is pure arithmetic on the number of clocks since reset release.
    function automatic logic [7:0] exp_an(input int unsigned n);
        if ((n % D) < BLANK) return 8'hFF;
        return ~(8'd1 << ((n / D) % 8));
    endfunction

    function automatic logic [6:0] exp_seg(input int unsigned n, input logic [7:0][3:0] bk,
                                           input logic er);
        int ix;
        int hi;
        ix = int'((n / D) % 8);
        hi = -1;
        for (int i = 0; i < 8; i++) if (bk[i] != 4'd0) hi = i;
        if ((n % D) < BLANK) return 7'h7F;
        if (er) begin
            if (ix == 2) return 7'h06;
            if (ix < 2) return 7'h2F;
            return 7'h7F;
        end
        if (LZB_P != 0 && ix > hi && ix != 0) return 7'h7F;
        return GLYPH[bk[ix]];
    endfunction

    function automatic logic exp_fd(input int unsigned n);
        return ((n + 1) % (8 * D)) == 0;
    endfunction

    logic [7:0][3:0] m_sh;
    logic [7:0][3:0] m_bk;
    logic            m_err;
    logic [1:0]      m_prev;
    int unsigned     n_edges;
    logic [16:0]     exp_q[$];
    logic [16:0]     sb_word;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_sh    <= '0;
            m_bk    <= '0;
            m_err   <= 1'b0;
            m_prev  <= 2'b10;
            n_edges <= 0;
            exp_q.delete();
            exp_q.push_back({8'hFF, 7'h7F, 1'b0, 1'b0});
        end else begin
            exp_q.push_back({exp_an(n_edges), exp_seg(n_edges, m_bk, m_err), exp_fd(n_edges),
                             (m_prev == 2'b01) && (status == 2'b10)});
            if (m_prev == 2'b01 && status == 2'b10) begin
                m_bk <= m_sh;
                m_sh <= '0;
            end else if (status == 2'b01 && pos < 4'd8) begin
                m_sh[pos[2:0]] <= data;
            end
            if (status == 2'b00) m_err <= 1'b1;
            m_prev  <= status;
            n_edges <= n_edges + 1;
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clock) begin
        if (chk_on) begin
            if (exp_q.size() == 0) begin
                check("exp_queue_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                sb_word = exp_q.pop_front();
                check("an", 32'(an), 32'(sb_word[16:9]));
                check("seg", 32'(seg), 32'(sb_word[8:2]));
                check("frame_done", 32'(frame_done), 32'(sb_word[1]));
                check("upd", 32'(upd), 32'(sb_word[0]));
                check("dp", 32'(dp), 32'd1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [1:0] st, input logic [3:0] p, input logic [3:0] d);
        status = st;
        pos    = p;
        data   = d;
        @(posedge clock);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(2'b10, 4'd0, 4'd0);
    endtask

    logic [6:0] seen [8];

    task automatic capture_frame();
        for (int i = 0; i < 8; i++) seen[i] = 7'h55;
        repeat (8 * D) begin
            @(negedge clock);
            for (int i = 0; i < 8; i++) if (an == ~(8'd1 << i)) seen[i] = seg;
        end
        @(posedge clock);
        #2;
    endtask

    task automatic check_frame(input string tag, input logic [55:0] exp);
        capture_frame();
        for (int i = 0; i < 8; i++) check($sformatf("%s_digit%0d", tag, i), 32'(seen[i]),
                                          32'(exp[i*7 +: 7]));
    endtask

    task automatic rand_session();
        int len;
        len = $urandom_range(0, 10);
        for (int k = 0; k < len; k++)
            drive(2'b01, 4'($urandom_range(0, 9)),
                  ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0);
        drive(($urandom_range(0, 5) == 0) ? 2'b11 : 2'b10, 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)));
        repeat ($urandom_range(0, 70))
            drive(($urandom_range(0, 3) == 0) ? 2'b11 : 2'b10, 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
    endtask

    // ---------------- stimulus ----------------
    int cnt;

    initial begin
        reset  = 1'b0;
        status = 2'b10;
        pos    = 4'd0;
        data   = 4'd0;
        #1;
        reset  = 1'b1;
        chk_on = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;

        // Power-up screen: only digit 0 shows "0".
        check_frame("t1", {{7{7'h7F}}, 7'h40});
        cnt = 0;
        repeat (8 * 8 * D) begin
            @(negedge clock);
            cnt += int'(frame_done);
        end
        check("t1_frame_done_per_8_frames", 32'(cnt), 32'd8);
        cnt = 0;
        repeat (8 * D) begin
            @(negedge clock);
            if (an == 8'hFF) cnt++;
        end
        check("t5_blank_cycles_per_frame", 32'(cnt), 32'(8 * BLANK));
        @(posedge clock);
        #2;

        // Stream "123" and commit.
        drive(2'b01, 4'd0, 4'd3);
        drive(2'b01, 4'd1, 4'd2);
        drive(2'b01, 4'd2, 4'd1);
        drive(2'b10, 4'd0, 4'd0);
        cnt = 0;
        repeat (6) begin
            @(negedge clock);
            cnt += int'(upd);
        end
        check("t2_upd_pulse_count", 32'(cnt), 32'd1);
        @(posedge clock);
        #2;
        check_frame("t2", {{5{7'h7F}}, 7'h79, 7'h24, 7'h30});

        // Long busy period: old bank stays on screen until the commit edge.
        repeat (3 * 8 * D) drive(2'b01, 4'd0, 4'd9);
        status = 2'b01;
        check_frame("t3_hold", {{5{7'h7F}}, 7'h79, 7'h24, 7'h30});
        drive(2'b10, 4'd0, 4'd0);
        idle(2);
        check_frame("t3_commit", {{7{7'h7F}}, 7'h10});

        for (int s = 0; s < 40; s++) rand_session();
        idle(4);

        // Sticky error screen survives later commits.
        drive(2'b00, 4'd0, 4'd0);
        idle(2);
        check_frame("t4", {{5{7'h7F}}, 7'h06, 7'h2F, 7'h2F});
        drive(2'b01, 4'd5, 4'd8);
        drive(2'b10, 4'd0, 4'd0);
        idle(2);
        check_frame("t4_after_commit", {{5{7'h7F}}, 7'h06, 7'h2F, 7'h2F});

        // Reset in the middle of a stream.
        drive(2'b01, 4'd0, 4'd5);
        drive(2'b01, 4'd1, 4'd6);
        reset = 1'b1;
        #1;
        check("t6_async_an", 32'(an), 32'hFF);
        check("t6_async_seg", 32'(seg), 32'h7F);
        repeat (2) @(posedge clock);
        #2;
        status = 2'b10;
        reset  = 1'b0;
        idle(2);
        check_frame("t6_after_reset", {{7{7'h7F}}, 7'h40});
        drive(2'b01, 4'd0, 4'd12);
        drive(2'b10, 4'd0, 4'd0);
        idle(2);
        check_frame("t6_dash", {{7{7'h7F}}, 7'h3F});

        for (int s = 0; s < 10; s++) rand_session();
        idle(4);

        @(posedge clock);
        #2;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
